imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the core's instruction fetch path. The core only reads instruction memory; this block fills it.
- Accepts a framed byte stream from the host, assembles little-endian 32-bit words and issues single-cycle writes into the instruction memory.
- Holds the core disabled while loading. Releases it once the image is complete and valid.
- Sits beside the core top level: drives the memory write port and the core `enable` input.

Parameters:
- ADDR_W, 8: word-address width. Memory depth DEPTH = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5: frame-start byte.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- byte_valid  in  1  host byte strobe.
- byte_data  in  8  host byte.
- byte_ready  out  1  byte accepted when byte_valid && byte_ready.
- imem_we  out  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  write data.
- core_enable  out  1  drives the core `enable` input.
- busy  out  1  frame in progress.
- done  out  1  last frame loaded successfully.
- error  out  1  last frame rejected.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is sampled on the rising edge of clk while reset==0.
  - Reset value of every output is 0, except byte_ready = 1. core_enable = 0 out of reset, so the core never runs before a load.
- byte_ready = 1 in every state. The block never stalls; accept = byte_valid.
- States and transitions:
  - IDLE:
    - Accepted byte == SYNC_BYTE -> LEN0.
    - Any other byte is ignored.
  - LEN0: accepted byte -> WC[7:0]; go to LEN1. busy = 1 from entry into LEN0.
  - LEN1: accepted byte -> WC[15:8]. Then:
    - WC > DEPTH -> ERROR.
    - WC == 0 -> CHECK if CHECKSUM_EN is defined, else DONE.
    - Otherwise -> DATA.
    - Word index and imem_addr are cleared on this transition.
  - DATA:
    - Byte k of each word (k = 0..3) goes to bits [8k+7:8k]. The 2-bit byte counter wraps.
    - On the 4th byte: the word is copied to the imem_wdata register, and imem_we = 1 in the next cycle with imem_addr = word index.
    - The index increments in the cycle after the pulse. Back-to-back words on consecutive cycles are legal.
    - After the last word's 4th byte -> CHECK if CHECKSUM_EN is defined, else DONE. The final write pulse still occurs one cycle later.
    - SYNC_BYTE values inside LEN0, LEN1 or DATA are payload; there is no resynchronisation.
  - DONE: done = 1, busy = 0, core_enable = 1.
  - ERROR: error = 1, busy = 0, core_enable = 0.
  - DONE/ERROR + accepted SYNC_BYTE -> LEN0: clears done and error, drops core_enable the same cycle and sets busy. Other bytes are ignored.
- Write behaviour:
  - imem_addr and imem_wdata hold their last values between pulses.
  - imem_we is never asserted outside the cycle after a 4th data byte.
- Boundaries:
  - WC == DEPTH is legal; the last write goes to address DEPTH-1.
  - A partial word is never written.
  - Reset mid-frame: state returns to IDLE and all outputs take their reset values. No pending write pulse is issued. Words already written remain in memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every byte after SYNC (length bytes and data bytes) is kept.
  - State CHECK accepts one byte. If it equals the running XOR -> DONE, else -> ERROR.
  - In the error case, words already written stay in memory and core_enable stays 0.
- Undefined: no CHECK state and no checksum byte. DATA/LEN1 go straight to DONE as described above.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> imem_we=0, core_enable=0, busy=0, done=0, error=0, byte_ready=1.
- Normal load, checksum enabled. Send A5 02 00 13 00 00 00 93 0F 10 00 9D ->
  - Writes addr0=0x00000013, then addr1=0x00100F93, each pulse one cycle after its 4th byte.
  - Then done=1 and core_enable=1.
- Empty and re-arm:
  - Send A5 00 00 00 (checksum 00) -> done=1 with zero write pulses.
  - A further A5 -> done=0, core_enable=0, busy=1.
- Oversize, ADDR_W=8: send A5 01 01 -> error=1 immediately after the 3rd byte, no writes, core_enable=0.
- Bad checksum: the load from the normal-load scenario with final byte 9C ->
  - Both writes still occur.
  - Then error=1 and core_enable=0.
- Noise and reset mid-frame:
  - Bytes 55 FF in IDLE are ignored, busy=0.
  - Send A5 01 00 13 00, then pulse reset -> no write pulse, state IDLE, core_enable=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream plus instruction-memory write port.
// slave = the loader (consumes bytes, drives writes); master = its environment.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed host byte stream
// (SYNC, WC lo, WC hi, WC little-endian words[, checksum]) and gates the core.
// Ports: clk, reset (sync, active-low), bus (imem_loader_if.slave: byte
// stream in, imem write port out), core_enable, busy, done, error.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    output logic         core_enable,
    output logic         busy,
    output logic         done,
    output logic         error
);

    localparam int          DEPTH   = 1 << ADDR_W;
    localparam logic [16:0] DEPTH_V = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    logic [7:0]        wc_lo;
    logic [15:0]       words_left;
    logic [1:0]        bcnt;
    logic [23:0]       word;
    logic [ADDR_W-1:0] widx;

    logic        accept;
    logic [7:0]  din;
    logic [15:0] wc_new;

    // The loader never back-pressures the host.
    assign bus.byte_ready = 1'b1;
    assign accept = bus.byte_valid;
    assign din    = bus.byte_data;
    assign wc_new = {din, wc_lo};

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of everything after SYNC; restarts on each SYNC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csum <= 8'h00;
        end else if (accept) begin
            if (state == S_IDLE || state == S_DONE || state == S_ERROR)
                csum <= 8'h00;
            else
                csum <= csum ^ din;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            core_enable    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            wc_lo          <= '0;
            words_left     <= '0;
            bcnt           <= '0;
            word           <= '0;
            widx           <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            // Index advances in the cycle after each write pulse.
            if (bus.imem_we)
                widx <= widx + 1'b1;

            if (accept) begin
                unique case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (din == SYNC_BYTE) begin
                            state       <= S_LEN0;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            error       <= 1'b0;
                            core_enable <= 1'b0;
                        end
                    end
                    S_LEN0: begin
                        wc_lo <= din;
                        state <= S_LEN1;
                    end
                    S_LEN1: begin
                        widx          <= '0;
                        bus.imem_addr <= '0;
                        bcnt          <= '0;
                        words_left    <= wc_new;
                        if ({1'b0, wc_new} > DEPTH_V) begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else if (wc_new == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHECK;
`else
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            core_enable <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        bcnt <= bcnt + 2'd1;
                        unique case (bcnt)
                            2'd0: word[7:0]   <= din;
                            2'd1: word[15:8]  <= din;
                            2'd2: word[23:16] <= din;
                            2'd3: begin
                                bus.imem_wdata <= {din, word};
                                bus.imem_we    <= 1'b1;
                                bus.imem_addr  <= widx;
                                words_left     <= words_left - 16'd1;
                                if (words_left == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state <= S_CHECK;
`else
                                    state       <= S_DONE;
                                    busy        <= 1'b0;
                                    done        <= 1'b1;
                                    core_enable <= 1'b1;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    S_CHECK: begin
                        busy <= 1'b0;
                        if (din == csum) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            core_enable <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus randomized frames checked
// against a frame-level reference model of the loader.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic core_enable, busy, done, error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .core_enable(core_enable),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t seen[$];
    wr_t expq[$];

    always @(negedge clk)
        if (bus.imem_we === 1'b1)
            seen.push_back('{a: bus.imem_addr, d: bus.imem_wdata});

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // kind: 0 byte, 1 reset pulse, 2 idle cycle
    // mode: 0 always, 1 checksum build only, 2 plain build only
    // st  : {busy, done, error, core_enable, imem_we}
    typedef struct {
        int                k;
        logic [7:0]        b;
        int                m;
        logic [4:0]        st;
        logic [ADDR_W-1:0] wa;
        logic [31:0]       wd;
    } vec_t;

    vec_t tbl[$];

    localparam logic [4:0] B = 5'b10000;
    localparam logic [4:0] D = 5'b01000;
    localparam logic [4:0] E = 5'b00100;
    localparam logic [4:0] C = 5'b00010;
    localparam logic [4:0] W = 5'b00001;

    function automatic void v(int k, logic [7:0] b, int m, logic [4:0] st,
                              logic [ADDR_W-1:0] wa = '0,
                              logic [31:0] wd = '0);
        tbl.push_back('{k: k, b: b, m: m, st: st, wa: wa, wd: wd});
    endfunction

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          pd, pe, over, bad, ok;
        int          wc, r;
        logic [7:0]  cs, nb;
        logic [31:0] w;

        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // reset
        v(1, 8'h00, 0, 5'b0);
        // normal load
        v(0, 8'hA5, 0, B); v(0, 8'h02, 0, B); v(0, 8'h00, 0, B);
        v(0, 8'h13, 0, B); v(0, 8'h00, 0, B); v(0, 8'h00, 0, B);
        v(0, 8'h00, 0, B | W, 8'd0, 32'h0000_0013);
        v(0, 8'h93, 0, B); v(0, 8'h0F, 0, B); v(0, 8'h10, 0, B);
        v(0, 8'h00, 1, B | W, 8'd1, 32'h0010_0F93);
        v(0, 8'h00, 2, D | C | W, 8'd1, 32'h0010_0F93);
        v(0, 8'h9D, 1, D | C);
        v(2, 8'h00, 0, D | C);
        // empty load and re-arm
        v(0, 8'hA5, 0, B); v(0, 8'h00, 0, B);
        v(0, 8'h00, 1, B); v(0, 8'h00, 2, D | C);
        v(0, 8'h00, 1, D | C);
        v(0, 8'hA5, 0, B);
        // oversize (257 words)
        v(0, 8'h01, 0, B); v(0, 8'h01, 0, E);
        v(2, 8'h00, 0, E);
        // bad checksum
        v(0, 8'hA5, 1, B); v(0, 8'h02, 1, B); v(0, 8'h00, 1, B);
        v(0, 8'h13, 1, B); v(0, 8'h00, 1, B); v(0, 8'h00, 1, B);
        v(0, 8'h00, 1, B | W, 8'd0, 32'h0000_0013);
        v(0, 8'h93, 1, B); v(0, 8'h0F, 1, B); v(0, 8'h10, 1, B);
        v(0, 8'h00, 1, B | W, 8'd1, 32'h0010_0F93);
        v(0, 8'h9C, 1, E);
        // noise, then reset mid-frame
        v(1, 8'h00, 0, 5'b0);
        v(0, 8'h55, 0, 5'b0); v(0, 8'hFF, 0, 5'b0);
        v(0, 8'hA5, 0, B); v(0, 8'h01, 0, B); v(0, 8'h00, 0, B);
        v(0, 8'h13, 0, B); v(0, 8'h00, 0, B);
        v(1, 8'h00, 0, 5'b0); v(2, 8'h00, 0, 5'b0);
        v(0, 8'h00, 0, 5'b0);

        @(negedge clk);
        foreach (tbl[i]) begin
            if ((tbl[i].m == 1 && !CK) || (tbl[i].m == 2 && CK))
                continue;
            unique case (tbl[i].k)
                0: put(tbl[i].b);
                1: do_reset();
                default: @(negedge clk);
            endcase
            check($sformatf("vec%0d status", i),
                  64'({busy, done, error, core_enable, bus.imem_we}),
                  64'(tbl[i].st));
            if (tbl[i].st[0])
                check($sformatf("vec%0d write", i),
                      64'({bus.imem_addr, bus.imem_wdata}),
                      64'({tbl[i].wa, tbl[i].wd}));
            if (i == 0)
                check("byte_ready", 64'(bus.byte_ready), 64'(1'b1));
        end

        // randomized frames against the frame-level model
        do_reset();
        pd = 1'b0;
        pe = 1'b0;
        for (int f = 0; f < 40; f++) begin
            @(negedge clk);
            seen.delete();
            expq.delete();
            repeat ($urandom_range(0, 2)) begin
                nb = 8'($urandom);
                if (nb == 8'hA5) nb = 8'h5A;
                put(nb);
                gap();
            end
            check($sformatf("f%0d idle", f),
                  64'({busy, done, error}), 64'({1'b0, pd, pe}));

            r    = int'($urandom_range(0, 9));
            over = (f != 0) && (r < 2);
            bad  = CK && !over && (r == 2);
            if (f == 0)  wc = DEPTH;
            else if (over) wc = int'($urandom_range(DEPTH + 1, 65535));
            else wc = int'($urandom_range(0, 6));

            put(8'hA5);
            check($sformatf("f%0d busy", f), 64'(busy), 64'(1'b1));
            gap();
            put(8'(wc));
            gap();
            put(8'(wc >> 8));
            cs = 8'(wc) ^ 8'(wc >> 8);
            if (!over) begin
                for (int i = 0; i < wc; i++) begin
                    w = $urandom;
                    expq.push_back('{a: ADDR_W'(i), d: w});
                    for (int k = 0; k < 4; k++) begin
                        gap();
                        put(w[8*k +: 8]);
                        cs = cs ^ w[8*k +: 8];
                    end
                    check($sformatf("f%0d w%0d", f, i),
                          64'({bus.imem_we, bus.imem_addr, bus.imem_wdata}),
                          64'({1'b1, ADDR_W'(i), w}));
                end
                if (CK) begin
                    gap();
                    put(bad ? (cs ^ 8'h01) : cs);
                end
            end
            @(negedge clk);
            ok = !over && !bad;
            check($sformatf("f%0d final", f),
                  64'({busy, done, error, core_enable}),
                  64'({1'b0, ok, !ok, ok}));
            check($sformatf("f%0d wr count", f),
                  64'(seen.size()), 64'(expq.size()));
            for (int i = 0; i < expq.size() && i < seen.size(); i++)
                if (i < 8 || i == expq.size() - 1)
                    check($sformatf("f%0d wr%0d", f, i),
                          64'(seen[i]), 64'(expq[i]));
            pd = ok;
            pe = !ok;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
